multi_byte_add_ctrl: RTL and testbench



---
 rtl/multi_byte_add_ctrl.sv | 112 +++++++++++
 tb/tb_multi_byte_add_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_byte_add_ctrl.sv
// multi_byte_add_ctrl: adds two NBYTES-byte operands one byte per clock through an external 8-bit adder.
// done pulses in the cycle after edge NBYTES; start is dropped outside IDLE. Define SIGNED_OVF_EN for the ovf port.
module multi_byte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                cin,
  output logic [7:0]          A,
  output logic [7:0]          B,
  output logic                C0,
  output logic                E,
  input  logic [7:0]          S,
  input  logic                C8,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                busy,
  output logic                done
`ifdef SIGNED_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  logic [1:0]          state;
  logic [KW-1:0]       k;
  logic [8*NBYTES-1:0] a_lat;
  logic [8*NBYTES-1:0] b_lat;
  logic                cin_lat;
  logic                carry_reg;
  logic [7:0]          a_byte;
  logic [7:0]          b_byte;
  logic                in_add;

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == KW'(i)) begin
        a_byte = a_lat[8*i +: 8];
        b_byte = b_lat[8*i +: 8];
      end
    end
  end

  // Adder inputs are forced to zero outside ADD so the adder sees a quiet bus.
  assign in_add = (state == ST_ADD);
  assign A      = in_add ? a_byte : 8'h00;
  assign B      = in_add ? b_byte : 8'h00;
  assign C0     = in_add & ((k == '0) ? cin_lat : carry_reg);
  assign E      = in_add;
  assign busy   = in_add;
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      cin_lat   <= 1'b0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_lat   <= op_a;
            b_lat   <= op_b;
            cin_lat <= cin;
            k       <= '0;
            state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (k == KW'(i)) sum[8*i +: 8] <= S;
          end
          carry_reg <= C8;
          k         <= k + KW'(1);
          if (k == K_LAST) begin
            cout  <= C8;
            state <= ST_DONE;
`ifdef SIGNED_OVF_EN
            // Overflow: like-signed operands produced a result of the other sign.
            ovf   <= (a_lat[8*NBYTES-1] == b_lat[8*NBYTES-1]) &&
                     (S[7] != a_lat[8*NBYTES-1]);
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// Directed bench for multi_byte_add_ctrl (NBYTES=4) with a behavioural 8-bit adder on the S/C8 side.
module tb_multi_byte_add_ctrl;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   op_a = '0;
  logic [31:0]   op_b = '0;
  logic          cin = 1'b0;
  logic [7:0]    A;
  logic [7:0]    B;
  logic          C0;
  logic          E;
  logic [7:0]    S;
  logic          C8;
  logic [31:0]   sum;
  logic          cout;
  logic          busy;
  logic          done;
`ifdef SIGNED_OVF_EN
  logic          ovf;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] prev_sum = '0;

  always #5 clk = ~clk;

  // Adder model; drives a junk value when disabled so an unqualified sample shows up.
  assign {C8, S} = E ? ({1'b0, A} + {1'b0, B} + {8'h00, C0}) : 9'h155;

  multi_byte_add_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .A     (A),
    .B     (B),
    .C0    (C0),
    .E     (E),
    .S     (S),
    .C8    (C8),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
`ifdef SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({A, B, C0, E, busy, done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got A=%h B=%h C0=%b E=%b busy=%b done=%b, want all 0", A, B, C0, E, busy, done);
    end
    vectors++;
    if ({sum, cout} !== 33'h0) begin
      miscompares++;
      $display("FAIL reset_result: got sum=%h cout=%b, want 0/0", sum, cout);
    end
`ifdef SIGNED_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
  endtask

  // One complete operation; glitch_i>0 pulses start with other operands during that ADD cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input int glitch_i, input string nm);
    logic [3:0]  cin_k;
    logic [8:0]  t;
    logic        cc;
    logic [31:0] exp_part;
    int          done_cnt;
    cc = c;
    for (int j = 0; j < NB; j++) begin
      cin_k[j] = cc;
      t  = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]} + {8'h00, cc};
      cc = t[8];
    end
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = ~a; op_b = ~b; cin = ~c;
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == glitch_i) begin
        start = 1'b1; op_a = 32'h0F0F0F0F; op_b = 32'h01010101; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      vectors++;
      if (busy !== (i <= NB) || E !== (i <= NB)) begin
        miscompares++;
        $display("FAIL %s busy_e[%0d]: got busy=%b E=%b, want %b", nm, i, busy, E, (i <= NB));
      end
      vectors++;
      if (done !== (i == NB + 1)) begin
        miscompares++;
        $display("FAIL %s done[%0d]: got %b want %b", nm, i, done, (i == NB + 1));
      end
      if (done === 1'b1) done_cnt++;
      vectors++;
      if (i <= NB) begin
        if (A !== a[8*(i-1) +: 8] || B !== b[8*(i-1) +: 8] || C0 !== cin_k[i-1]) begin
          miscompares++;
          $display("FAIL %s adder_in[k=%0d]: got A=%h B=%h C0=%b, want A=%h B=%h C0=%b",
                   nm, i - 1, A, B, C0, a[8*(i-1) +: 8], b[8*(i-1) +: 8], cin_k[i-1]);
        end
      end else if ({A, B, C0} !== 17'h0) begin
        miscompares++;
        $display("FAIL %s adder_idle[%0d]: got A=%h B=%h C0=%b, want 0", nm, i, A, B, C0);
      end
      if (i <= NB + 1) begin
        for (int j = 0; j < NB; j++)
          exp_part[8*j +: 8] = (j < i - 1) ? exp_sum[8*j +: 8] : prev_sum[8*j +: 8];
        vectors++;
        if (sum !== exp_part) begin
          miscompares++;
          $display("FAIL %s partial_sum[%0d]: got %h want %h", nm, i, sum, exp_part);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL %s done_count: got %0d want 1", nm, done_cnt);
    end
    vectors++;
    if (sum !== exp_sum || cout !== exp_cout) begin
      miscompares++;
      $display("FAIL %s result: got sum=%h cout=%b, want sum=%h cout=%b", nm, sum, cout, exp_sum, exp_cout);
    end
`ifdef SIGNED_OVF_EN
    vectors++;
    if (ovf !== exp_ovf) begin
      miscompares++;
      $display("FAIL %s ovf: got %b want %b", nm, ovf, exp_ovf);
    end
`else
    if (exp_ovf) begin end
`endif
    prev_sum = exp_sum;
  endtask

  task automatic test_basic_add();
    run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0, "basic");
  endtask

  task automatic test_full_ripple();
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 0, "ripple");
  endtask

  task automatic test_carry_in_only();
    run_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 0, "cin_only");
  endtask

  task automatic test_signed_ovf();
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0, "sovf_pos");
  endtask

  task automatic test_ignored_start();
    run_op(32'h01020304, 32'h10203040, 1'b0, 32'h11223344, 1'b0, 1'b0, 3, "ign_start");
  endtask

  task automatic test_signed_ovf_neg();
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0, "sovf_neg");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op_a = 32'hAAAAAAAA; op_b = 32'h55555555; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({A, B, C0, E, busy, done} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl: got A=%h B=%h C0=%b E=%b busy=%b done=%b, want all 0", A, B, C0, E, busy, done);
    end
    vectors++;
    if ({sum, cout} !== 33'h0) begin
      miscompares++;
      $display("FAIL mid_reset_result: got sum=%h cout=%b, want 0/0", sum, cout);
    end
`ifdef SIGNED_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ovf: got %b want 0", ovf);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    prev_sum = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: got busy=%b done=%b, want 0/0", busy, done);
    end
    run_op(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_full_ripple();
    test_carry_in_only();
    test_signed_ovf();
    test_ignored_start();
    test_signed_ovf_neg();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
